// File: rtl/text_buffer_writer.sv
// text_buffer_writer
//   Character-cell text RAM (ROW_NUMBER x COL_NUMBER) written from a byte
//   stream at a hardware cursor, read asynchronously by the pixel encoder.
//   Handles printable codes, newline (0x0A/0x0D), backspace (0x08) and
//   clear-screen (0x0C). Text running past the last row scrolls the screen
//   up one row, one cell copied per cycle.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   in_valid/in_ready    byte handshake; in_char is the code
//   char_row/char_col    encoder read coordinates
//   character_id         cell contents at (char_row, char_col), combinational
//   cursor_row/col       current cursor
//   busy                 high whenever the block is not IDLE
// Optional feature: define TEXT_BUFFER_CURSOR_BLINK_EN to overlay a blinking
//   CURSOR_ID on the cursor cell at the read port (RAM is untouched).
module text_buffer_writer #(
  parameter int ROW_NUMBER     = 15,
  parameter int COL_NUMBER     = 40,
  parameter int ROW_BIT_LEN    = 4,
  parameter int COL_BIT_LEN    = 6,
  parameter int CHAR_ID_LENGTH = 8,
  parameter int BLANK_ID       = 32,
  parameter int CURSOR_ID      = 95,
  parameter int BLINK_CYCLES   = 12500000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHAR_ID_LENGTH-1:0] in_char,
  input  logic [ROW_BIT_LEN-1:0]    char_row,
  input  logic [COL_BIT_LEN-1:0]    char_col,
  output logic [CHAR_ID_LENGTH-1:0] character_id,
  output logic [ROW_BIT_LEN-1:0]    cursor_row,
  output logic [COL_BIT_LEN-1:0]    cursor_col,
  output logic                      busy
);

  localparam int TOTAL = ROW_NUMBER * COL_NUMBER;
  localparam int AW    = $clog2(TOTAL);
  localparam logic [AW-1:0]             LAST_ADDR = AW'(TOTAL - 1);
  localparam logic [AW-1:0]             LAST_COPY = AW'((ROW_NUMBER - 1) * COL_NUMBER - 1);
  localparam logic [ROW_BIT_LEN-1:0]    LAST_ROW  = ROW_BIT_LEN'(ROW_NUMBER - 1);
  localparam logic [COL_BIT_LEN-1:0]    LAST_COL  = COL_BIT_LEN'(COL_NUMBER - 1);
  localparam logic [CHAR_ID_LENGTH-1:0] BLANK     = CHAR_ID_LENGTH'(BLANK_ID);

  typedef enum logic [1:0] {IDLE, SCROLL, CLEAR_LINE, CLEAR_ALL} state_t;

  state_t                   state_q, state_d;
  logic [ROW_BIT_LEN-1:0]   cursor_row_q, cursor_row_d;
  logic [COL_BIT_LEN-1:0]   cursor_col_q, cursor_col_d;
  logic [AW-1:0]            ptr_q, ptr_d;
  logic                     in_ready_q, in_ready_d;
  logic                     busy_q, busy_d;

  logic [CHAR_ID_LENGTH-1:0] mem [TOTAL];

  logic                      we;
  logic [AW-1:0]             waddr;
  logic [CHAR_ID_LENGTH-1:0] wdata;
  logic [AW-1:0]             cur_addr;
  logic [AW-1:0]             src_addr;
  logic                      accept;

  assign accept   = in_valid & in_ready_q;
  assign cur_addr = AW'(cursor_row_q) * AW'(COL_NUMBER) + AW'(cursor_col_q);
  // Scroll source is one row below the scan pointer; parked at 0 otherwise
  // so the index never leaves the array.
  assign src_addr = (state_q == SCROLL) ? ptr_q + AW'(COL_NUMBER) : '0;

  always_comb begin
    state_d      = state_q;
    cursor_row_d = cursor_row_q;
    cursor_col_d = cursor_col_q;
    ptr_d        = ptr_q;
    we           = 1'b0;
    waddr        = ptr_q;
    wdata        = BLANK;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_char == 8'h0A || in_char == 8'h0D) begin
            cursor_col_d = '0;
            if (cursor_row_q != LAST_ROW) cursor_row_d = cursor_row_q + 1'b1;
            else begin
              state_d = SCROLL;
              ptr_d   = '0;
            end
          end else if (in_char == 8'h08) begin
            // Both the same-row and previous-row cases blank the linear
            // address just before the cursor.
            if (cursor_col_q != '0) begin
              cursor_col_d = cursor_col_q - 1'b1;
              we           = 1'b1;
              waddr        = cur_addr - 1'b1;
            end else if (cursor_row_q != '0) begin
              cursor_row_d = cursor_row_q - 1'b1;
              cursor_col_d = LAST_COL;
              we           = 1'b1;
              waddr        = cur_addr - 1'b1;
            end
          end else if (in_char == 8'h0C) begin
            cursor_row_d = '0;
            cursor_col_d = '0;
            ptr_d        = '0;
            state_d      = CLEAR_ALL;
          end else begin
            we    = 1'b1;
            waddr = cur_addr;
            wdata = in_char;
            if (cursor_col_q != LAST_COL) cursor_col_d = cursor_col_q + 1'b1;
            else begin
              cursor_col_d = '0;
              if (cursor_row_q != LAST_ROW) cursor_row_d = cursor_row_q + 1'b1;
              else begin
                state_d = SCROLL;
                ptr_d   = '0;
              end
            end
          end
        end
      end
      SCROLL: begin
        we    = 1'b1;
        wdata = mem[src_addr];
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_COPY) state_d = CLEAR_LINE;
      end
      CLEAR_LINE: begin
        we    = 1'b1;
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_ADDR) begin
          state_d      = IDLE;
          ptr_d        = '0;
          cursor_row_d = LAST_ROW;
          cursor_col_d = '0;
        end
      end
      CLEAR_ALL: begin
        we    = 1'b1;
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_ADDR) begin
          state_d = IDLE;
          ptr_d   = '0;
        end
      end
      default: state_d = CLEAR_ALL;
    endcase
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= CLEAR_ALL;
      cursor_row_q <= '0;
      cursor_col_q <= '0;
      ptr_q        <= '0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cursor_row_q <= cursor_row_d;
      cursor_col_q <= cursor_col_d;
      ptr_q        <= ptr_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
    end
  end

  // Text RAM: contents intentionally not reset (CLEAR_ALL blanks it).
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign cursor_row = cursor_row_q;
  assign cursor_col = cursor_col_q;

  // Encoder read port
  logic          rd_ok;
  logic [AW-1:0] rd_addr;
  assign rd_ok   = (int'(char_row) < ROW_NUMBER) && (int'(char_col) < COL_NUMBER);
  assign rd_addr = rd_ok ? AW'(char_row) * AW'(COL_NUMBER) + AW'(char_col) : '0;

`ifdef TEXT_BUFFER_CURSOR_BLINK_EN
  logic [31:0] blink_cnt_q, blink_cnt_d;
  logic        blink_on_q, blink_on_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q + 32'd1;
    blink_on_d  = blink_on_q;
    if (blink_cnt_q == 32'(BLINK_CYCLES - 1)) begin
      blink_cnt_d = '0;
      blink_on_d  = ~blink_on_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  always_comb begin
    character_id = mem[rd_addr];
    if (!rd_ok || state_q == CLEAR_ALL) character_id = BLANK;
    else if (state_q == IDLE && blink_on_q &&
             char_row == cursor_row_q && char_col == cursor_col_q)
      character_id = CHAR_ID_LENGTH'(CURSOR_ID);
  end
`else
  logic unused_blink_params;
  assign unused_blink_params = ^{CURSOR_ID, BLINK_CYCLES};

  always_comb begin
    character_id = mem[rd_addr];
    if (!rd_ok || state_q == CLEAR_ALL) character_id = BLANK;
  end
`endif

endmodule

// File: tb/tb_text_buffer_writer.sv
module tb_text_buffer_writer;
  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_char;
  logic [3:0] char_row;
  logic [5:0] char_col;
  logic [7:0] character_id;
  logic [3:0] cursor_row;
  logic [5:0] cursor_col;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_mem [15][40];

  always #5 clk = ~clk;

  text_buffer_writer #(.BLINK_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_char(in_char), .char_row(char_row), .char_col(char_col),
    .character_id(character_id), .cursor_row(cursor_row),
    .cursor_col(cursor_col), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    in_valid = 1'b1;
    in_char  = c;
    tick();
    in_valid = 1'b0;
  endtask

  // Counts cycles until busy drops, bounded.
  task automatic wait_idle(input string tag, input int expect_n);
    int n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    check(tag, n, expect_n);
  endtask

  task automatic read_cell(input int r, input int c, output logic [7:0] v);
    char_row = 4'(r);
    char_col = 6'(c);
    #1;
    v = character_id;
  endtask

  task automatic check_cursor(input string tag, input int r, input int c);
    check({tag, "_row"}, cursor_row, r);
    check({tag, "_col"}, cursor_col, c);
  endtask

  task automatic check_screen(input string tag);
    int bad = 0;
    logic [7:0] v;
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 40; c++) begin
        read_cell(r, c, v);
        if (v !== exp_mem[r][c]) bad++;
      end
    check(tag, bad, 0);
  endtask

  task automatic exp_blank();
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 40; c++) exp_mem[r][c] = 8'd32;
  endtask

  task automatic exp_scroll();
    for (int r = 0; r < 14; r++)
      for (int c = 0; c < 40; c++) exp_mem[r][c] = exp_mem[r+1][c];
    for (int c = 0; c < 40; c++) exp_mem[14][c] = 8'd32;
  endtask

  initial begin
    logic [7:0] v;
    reset = 1'b1; in_valid = 1'b0; in_char = 8'h00; char_row = '0; char_col = '0;
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 1);
    check_cursor("rst_cursor", 0, 0);
    check("rst_read_blank", character_id, 8'd32);

    // Hold a valid code through the post-reset clear; it must not be taken.
    in_valid = 1'b1; in_char = 8'h41;
    @(posedge clk); #1 reset = 1'b0;
    wait_idle("post_reset_busy_cycles", 600);
    check("post_reset_ready", in_ready, 1);
    in_valid = 1'b0;
    check_cursor("post_reset_cursor", 0, 0);
    exp_blank();
    check_screen("post_reset_screen");

    // Back-to-back printables
    send(8'h41);
    check("ready_after_first", in_ready, 1);
    send(8'h42);
    read_cell(0, 0, v); check("cell_0_0_A", v, 8'h41);
    read_cell(0, 1, v); check("cell_0_1_B", v, 8'h42);
    check_cursor("after_AB", 0, 2);

    // Backspace within a row, then newlines
    send(8'h08);
    check_cursor("bs_in_row", 0, 1);
    read_cell(0, 1, v); check("bs_cell_blank", v, 8'd32);
    read_cell(0, 0, v); check("bs_keeps_prev", v, 8'h41);
    send(8'h0D);
    check_cursor("cr_newline", 1, 0);
    send(8'h0A);
    check_cursor("lf_newline", 2, 0);

    // Clear screen
    send(8'h0C);
    check("clear_busy", busy, 1);
    wait_idle("clear_busy_cycles", 600);
    check_cursor("clear_cursor", 0, 0);
    exp_blank();
    check_screen("clear_screen");

    // Row wrap, backspace across the row boundary
    for (int i = 0; i < 40; i++) begin send(8'h41); exp_mem[0][i] = 8'h41; end
    check_cursor("wrap_cursor", 1, 0);
    send(8'h08);
    exp_mem[0][39] = 8'd32;
    check_cursor("bs_prev_row", 0, 39);
    check_screen("bs_prev_row_screen");

    // Backspace at (0,0) is a no-op
    send(8'h0C); wait_idle("clear2_busy_cycles", 600);
    send(8'h5A);
    send(8'h08);
    check_cursor("bs_to_origin", 0, 0);
    send(8'h08);
    check_cursor("bs_at_origin", 0, 0);
    check("bs_origin_not_busy", busy, 0);
    exp_blank();
    check_screen("bs_origin_screen");

    // Fill rows 0-13, row 14 via wrap triggers a scroll
    for (int r = 0; r < 14; r++)
      for (int c = 0; c < 40; c++) begin send(8'(8'h41 + r)); exp_mem[r][c] = 8'(8'h41 + r); end
    check_cursor("fill_cursor", 14, 0);
    for (int c = 0; c < 40; c++) begin send(8'h4F); exp_mem[14][c] = 8'h4F; end
    check("wrap_scroll_busy", busy, 1);
    wait_idle("wrap_scroll_cycles", 600);
    exp_scroll();
    check_screen("wrap_scroll_screen");
    check_cursor("wrap_scroll_cursor", 14, 0);

    // Out-of-range reads, with non-blank data at the aliased addresses
    read_cell(0, 40, v); check("oob_col40", v, 8'd32);
    read_cell(3, 63, v); check("oob_col63", v, 8'd32);
    read_cell(15, 0, v); check("oob_row15", v, 8'd32);

    // Newline on the last row scrolls
    send(8'h0A);
    wait_idle("lf_scroll_cycles", 600);
    exp_scroll();
    check_screen("lf_scroll_screen");
    check_cursor("lf_scroll_cursor", 14, 0);

    // Reset 100 cycles into a scroll restarts the full clear
    send(8'h0A);
    repeat (100) tick();
    reset = 1'b1;
    #1;
    check("midrst_busy", busy, 1);
    check("midrst_ready", in_ready, 0);
    check_cursor("midrst_cursor", 0, 0);
    tick();
    reset = 1'b0;
    wait_idle("midrst_clear_cycles", 600);
    exp_blank();
    check_screen("midrst_screen");

`ifdef TEXT_BUFFER_CURSOR_BLINK_EN
    begin
      int hits = 0;
      char_row = 4'd0; char_col = 6'd0;
      for (int i = 0; i < 16; i++) begin
        tick();
        if (character_id === 8'd95) hits++;
        else if (character_id !== 8'd32) hits += 100;
      end
      check("blink_hits", hits, 8);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/text_buffer_writer.md
Name: text_buffer_writer

Overview:
- Owns the character-cell text RAM, ROW_NUMBER x COL_NUMBER cells, that the pixel encoder reads.
- Accepts a byte stream (keyboard/UART) over a valid/ready handshake and writes printable codes at a hardware cursor.
- Handles newline, backspace and clear-screen; scrolls the screen up when text runs past the last row.
- Provides an asynchronous read port indexed by the encoder's char_row/char_col that returns character_id in the same cycle.

Parameters:
ROW_NUMBER, 15, text rows
COL_NUMBER, 40, cells per row
ROW_BIT_LEN, 4, width of row indices
COL_BIT_LEN, 6, width of column indices
CHAR_ID_LENGTH, 8, character id width
BLANK_ID, 32, id written to empty cells
CURSOR_ID, 95, id shown at the cursor (optional feature only)
BLINK_CYCLES, 12500000, cycles per blink half-period (optional feature only)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  in_char holds a code
in_ready  out  1  block accepts a code this cycle
in_char  in  CHAR_ID_LENGTH  input code
char_row  in  ROW_BIT_LEN  read row, from the encoder
char_col  in  COL_BIT_LEN  read column, from the encoder
character_id  out  CHAR_ID_LENGTH  cell contents at (char_row, char_col); combinational
cursor_row  out  ROW_BIT_LEN  current cursor row
cursor_col  out  COL_BIT_LEN  current cursor column
busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- On reset: state=CLEAR_ALL, cursor=(0,0), in_ready=0, busy=1, scan pointer=0.
- Memory: ROW_NUMBER*COL_NUMBER entries.
  - Linear address = row*COL_NUMBER + col.
  - One synchronous write port and two asynchronous read ports (encoder read; scroll source).
  - Memory contents are not reset.
- Read port:
  - character_id = mem[char_row, char_col].
  - Returns BLANK_ID when char_row>=ROW_NUMBER, when char_col>=COL_NUMBER, or while state=CLEAR_ALL.
  - A cell written at edge N is visible from N onward; in the cycle before that edge the old value is shown.
- Handshake:
  - A transfer occurs on a rising edge with in_valid && in_ready.
  - in_ready = (state==IDLE), registered.
  - in_char is ignored when no transfer occurs.
- States and transitions:
  - IDLE: decodes an accepted code as follows.
    - 0x0A or 0x0D (newline): col=0. If row<ROW_NUMBER-1 then row+1; else go to SCROLL.
    - 0x08 (backspace): if col>0, col-1 and write BLANK_ID at the new position. If col=0 and row>0, row-1, col=COL_NUMBER-1, write BLANK_ID there. At (0,0) it is a no-op.
    - 0x0C (clear screen): cursor=(0,0), go to CLEAR_ALL.
    - Any other code: written to mem[cursor] in the accept cycle. Then col+1. At col=COL_NUMBER-1 it wraps: col=0, and row+1, or SCROLL if row is already the last row.
  - SCROLL:
    - Scan pointer p runs from 0 to (ROW_NUMBER-1)*COL_NUMBER-1.
    - Each cycle writes mem[p] <= mem[p+COL_NUMBER] and increments p.
    - After the last copy: p=(ROW_NUMBER-1)*COL_NUMBER, go to CLEAR_LINE.
  - CLEAR_LINE:
    - Writes BLANK_ID to mem[p], p+1, up to ROW_NUMBER*COL_NUMBER-1.
    - Then cursor=(ROW_NUMBER-1,0), go to IDLE.
  - CLEAR_ALL:
    - Writes BLANK_ID to mem[p] for p = 0 .. ROW_NUMBER*COL_NUMBER-1, one cell per cycle, then go to IDLE.
    - The cursor is already (0,0) on entry.
- Latency:
  - Printable, newline or backspace without scroll: 1 cycle; in_ready stays high, back-to-back accepts allowed.
  - Scroll: 600 cycles busy with defaults (560 copy + 40 clear).
  - Clear / post-reset: 600 cycles busy.
- Boundaries:
  - Reset asserted mid-SCROLL or mid-CLEAR restarts CLEAR_ALL; partial RAM contents are then fully overwritten.
  - Cursor never leaves range: row<=ROW_NUMBER-1, col<=COL_NUMBER-1.
  - The encoder may read at any time. During SCROLL/CLEAR_LINE it sees a partially moved screen; this is accepted.

Optional Feature:
- Macro name: TEXT_BUFFER_CURSOR_BLINK_EN.
- Defined:
  - A counter toggles a blink phase every BLINK_CYCLES clocks. The counter resets to 0 with phase=on.
  - In IDLE with phase=on, character_id returns CURSOR_ID when (char_row,char_col)==(cursor_row,cursor_col).
  - The RAM itself is not modified.
- Undefined: no counter, no substitution; character_id always reflects the RAM.

Test Plan:
- Release reset, hold in_valid=1: in_ready=0 for 600 cycles, then 1. Every (r,c) reads 32. Cursor (0,0).
- Send 'A'(0x41), 'B'(0x42): (0,0)=0x41, (0,1)=0x42. Cursor (0,2). Two consecutive accept cycles.
- Send 40 x 0x41: cursor wraps to (1,0). Then 0x08: cursor (0,39), cell (0,39)=32. Send 0x08 at (0,0): no change.
- Fill rows 0-14 with distinct ids (row r = 0x41+r), cursor at (14,0), send 0x0A:
  - busy high for 600 cycles.
  - Afterwards row r reads 0x42+r for r<14, row 14 reads 32.
  - Cursor (14,0).
- Write data, then send 0x0C: 600 busy cycles, all cells 32, cursor (0,0). Assert reset 100 cycles into a scroll: full 600-cycle clear follows.
- Read char_row=15 or char_col=40: character_id=32. With TEXT_BUFFER_CURSOR_BLINK_EN and BLINK_CYCLES=4: the cursor cell alternates CURSOR_ID/RAM value every 4 cycles.
